// File: rtl/encoder_4x2.sv
// 4-to-2 priority encoder (D3 highest) with valid and multi-hot flags.
// REGISTERED selects a one-cycle registered path or a purely combinational one.
module encoder_4x2 #(
    parameter bit REGISTERED = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic D3,
    input  logic D2,
    input  logic D1,
    input  logic D0,
    output logic O2,
    output logic O1,
    output logic valid,
    output logic multi_hot
);

    logic [1:0] enc_idx;
    logic       enc_valid;
    logic       enc_multi;

    always_comb begin
        enc_idx = 2'b00;
        if (D3)      enc_idx = 2'b11;
        else if (D2) enc_idx = 2'b10;
        else if (D1) enc_idx = 2'b01;
        else         enc_idx = 2'b00;
    end

    assign enc_valid = D3 | D2 | D1 | D0;
    // Any pair of set bits means popcount >= 2; implies valid by construction.
    assign enc_multi = (D3 & (D2 | D1 | D0)) | (D2 & (D1 | D0)) | (D1 & D0);

    generate
        if (REGISTERED) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    O2        <= 1'b0;
                    O1        <= 1'b0;
                    valid     <= 1'b0;
                    multi_hot <= 1'b0;
                end else begin
                    O2        <= enc_idx[1];
                    O1        <= enc_idx[0];
                    valid     <= enc_valid;
                    multi_hot <= enc_multi;
                end
            end
        end else begin : g_comb
            // clk and rst_n are intentionally unused in this build.
            assign O2        = enc_idx[1];
            assign O1        = enc_idx[0];
            assign valid     = enc_valid;
            assign multi_hot = enc_multi;
        end
    endgenerate

endmodule

// File: tb/tb_encoder_4x2.sv
// Bench for encoder_4x2: registered instance driven from a vector table plus
// reset sequences, and a combinational instance swept over all 16 inputs.
module tb_encoder_4x2;

    typedef struct {
        logic [3:0] d;
        logic [3:0] exp;   // {O2, O1, valid, multi_hot}
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic [3:0] c_d;
    logic       r_o2, r_o1, r_valid, r_multi;
    logic       c_o2, c_o1, c_valid, c_multi;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    encoder_4x2 #(.REGISTERED(1'b1)) dut_reg (
        .clk(clk), .rst_n(rst_n),
        .D3(d[3]), .D2(d[2]), .D1(d[1]), .D0(d[0]),
        .O2(r_o2), .O1(r_o1), .valid(r_valid), .multi_hot(r_multi)
    );

    encoder_4x2 #(.REGISTERED(1'b0)) dut_comb (
        .clk(clk), .rst_n(rst_n),
        .D3(c_d[3]), .D2(c_d[2]), .D1(c_d[1]), .D0(c_d[0]),
        .O2(c_o2), .O1(c_o1), .valid(c_valid), .multi_hot(c_multi)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {O2,O1,valid,multi_hot}=%b expected %b", name, act, exp);
        end
    endtask

    // driver: present a vector on the falling edge, check one edge later
    task automatic drive_and_check(input string name, input logic [3:0] vin, input logic [3:0] vexp);
        logic [3:0] e;
        @(negedge clk);
        d = vin;
        exp_q.push_back(vexp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(name, {r_o2, r_o1, r_valid, r_multi}, e);
    endtask

    vec_t       vecs[12];
    logic [3:0] comb_exp[16];

    initial begin
        vecs[0]  = '{4'b0001, 4'b0010};
        vecs[1]  = '{4'b0010, 4'b0110};
        vecs[2]  = '{4'b0100, 4'b1010};
        vecs[3]  = '{4'b1000, 4'b1110};
        vecs[4]  = '{4'b0011, 4'b0111};
        vecs[5]  = '{4'b0110, 4'b1011};
        vecs[6]  = '{4'b1100, 4'b1111};
        vecs[7]  = '{4'b1111, 4'b1111};
        vecs[8]  = '{4'b1000, 4'b1110};
        vecs[9]  = '{4'b0000, 4'b0000};
        vecs[10] = '{4'b0101, 4'b1011};
        vecs[11] = '{4'b1001, 4'b1111};

        comb_exp[0]  = 4'b0000; comb_exp[1]  = 4'b0010;
        comb_exp[2]  = 4'b0110; comb_exp[3]  = 4'b0111;
        comb_exp[4]  = 4'b1010; comb_exp[5]  = 4'b1011;
        comb_exp[6]  = 4'b1011; comb_exp[7]  = 4'b1011;
        comb_exp[8]  = 4'b1110; comb_exp[9]  = 4'b1111;
        comb_exp[10] = 4'b1111; comb_exp[11] = 4'b1111;
        comb_exp[12] = 4'b1111; comb_exp[13] = 4'b1111;
        comb_exp[14] = 4'b1111; comb_exp[15] = 4'b1111;

        // reset held with D = 1000 and clock running
        rst_n = 1'b0;
        d     = 4'b1000;
        c_d   = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", {r_o2, r_o1, r_valid, r_multi}, 4'b0000);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", {r_o2, r_o1, r_valid, r_multi}, 4'b1110);

        // table: one-hot sweep, priority, zero-after-1000, extras
        for (int i = 0; i < 12; i++)
            drive_and_check($sformatf("vec%0d_d%b", i, vecs[i].d), vecs[i].d, vecs[i].exp);

        // asynchronous reset between edges while O = 10
        drive_and_check("pre_async", 4'b0100, 4'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", {r_o2, r_o1, r_valid, r_multi}, 4'b0000);
        @(posedge clk);
        #1;
        check("async_reset_held", {r_o2, r_o1, r_valid, r_multi}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive_and_check("after_async", 4'b0010, 4'b0110);

        // in-flight result discarded: drive 1000, reset before its edge
        @(negedge clk);
        d = 4'b1000;
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("inflight_discard", {r_o2, r_o1, r_valid, r_multi}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive_and_check("after_discard", 4'b0001, 4'b0010);

        // combinational build: settle without waiting for a clock edge
        for (int v = 0; v < 16; v++) begin
            c_d = v[3:0];
            #1;
            check($sformatf("comb_d%b", v[3:0]), {c_o2, c_o1, c_valid, c_multi}, comb_exp[v]);
        end

        // combinational build ignores rst_n
        rst_n = 1'b0;
        c_d   = 4'b0110;
        #1;
        check("comb_ignores_reset", {c_o2, c_o1, c_valid, c_multi}, 4'b1011);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
